// File: rtl/apb_bridge_master.sv
// APB3 requester: turns a valid/ready command into SETUP/ACCESS transfers and
// returns read data or a timeout error on a single-cycle response strobe.
module apb_bridge_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PWRITE,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    cmd_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        cmd_ready = PREADY;
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          penable_d   = 1'b0;
          // A command waiting at completion chains straight into SETUP with PSELx held.
          if (cmd_valid) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            state_d  = SETUP;
          end else begin
            psel_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_bridge_master.sv
// Bench for apb_bridge_master: directed protocol scenarios plus randomized
// transactions checked against a transaction-level model of the bridge.
module tb_apb_bridge_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PSELx;
  logic          PENABLE;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] smem [16];
  logic [DW-1:0] mmem [16];
  int slave_wait = 0;
  int acc_cnt = 0;

  apb_bridge_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave: asserts PREADY after slave_wait ACCESS cycles, noise elsewhere.
  initial begin
    forever begin
      @(negedge PCLK);
      if (PSELx === 1'b1 && PENABLE === 1'b1) begin
        PREADY = (acc_cnt == slave_wait);
        if (PREADY && PWRITE) smem[PADDR[3:0]] = PWDATA;
        PRDATA = (PREADY && !PWRITE) ? smem[PADDR[3:0]] : DW'($urandom);
        acc_cnt++;
      end else begin
        PREADY  = 1'($urandom);
        PRDATA  = DW'($urandom);
        acc_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_cmd(input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Steps from SETUP until the response strobe; gathers observations only.
  task automatic run_to_rsp(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output bit got, output int acc, output int rdy, output bit stable);
    got = 0; acc = 0; rdy = 0; stable = 1;
    for (int c = 0; c < int'(TO) + 8; c++) begin
      @(negedge PCLK); #1;
      if (rsp_valid === 1'b1) begin
        got = 1;
        break;
      end
      if (PSELx === 1'b1 && PENABLE === 1'b1) begin
        acc++;
        if (cmd_ready === 1'b1) rdy++;
        if (PADDR !== a || PWRITE !== w || PWDATA !== d) stable = 0;
      end else begin
        stable = 0;
      end
    end
  endtask

  task automatic test_reset();
    drive_cmd(0, 0, '0, '0);
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    vectors++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err});
    end
    vectors++;
    if (PADDR !== '0 || PWDATA !== '0 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data: PADDR=%h PWDATA=%h rsp_rdata=%h want 0", PADDR, PWDATA, rsp_rdata);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
    end
    PRESETn = 1'b1;
  endtask

  task automatic test_zero_wait_write();
    slave_wait = 0;
    mmem[0] = 8'hA5;
    @(negedge PCLK); #1;
    drive_cmd(1, 1, 32'h10, 8'hA5);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL zw_accept: cmd_ready=%b want 1", cmd_ready);
    end
    @(negedge PCLK); #1;
    drive_cmd(0, 0, AW'($urandom), DW'($urandom));
    vectors++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid} !== 4'b1010 || PADDR !== 32'h10 || PWDATA !== 8'hA5) begin
      miscompares++;
      $display("FAIL zw_setup: sel/en/wr/rv=%b addr=%h wdata=%h want 1010 10 a5",
               {PSELx, PENABLE, PWRITE, rsp_valid}, PADDR, PWDATA);
    end
    @(negedge PCLK); #1;
    vectors++;
    if ({PSELx, PENABLE, cmd_ready} !== 3'b111 || PADDR !== 32'h10) begin
      miscompares++;
      $display("FAIL zw_access: sel/en/rdy=%b addr=%h want 111 10", {PSELx, PENABLE, cmd_ready}, PADDR);
    end
    @(negedge PCLK); #1;
    vectors++;
    if ({PSELx, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL zw_rsp: sel/en/rv/err=%b rdata=%h want 0010 00",
               {PSELx, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
    @(negedge PCLK); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL zw_pulse: rsp_valid=%b err=%b want 0 0", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_wait_read();
    bit got, stable; int acc, rdy;
    logic [DW-1:0] wd;
    wd = DW'($urandom);
    slave_wait = 3;
    @(negedge PCLK); #1;
    drive_cmd(1, 0, 32'h10, wd);
    @(negedge PCLK); #1;
    drive_cmd(0, 1, AW'($urandom), DW'($urandom));
    vectors++;
    if ({PSELx, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h10) begin
      miscompares++;
      $display("FAIL wr_setup: sel/en/wr=%b addr=%h want 100 10", {PSELx, PENABLE, PWRITE}, PADDR);
    end
    run_to_rsp(1'b0, 32'h10, wd, got, acc, rdy, stable);
    vectors++;
    if (!got || acc != 4 || !stable) begin
      miscompares++;
      $display("FAIL wr_access: got=%0d access_cycles=%0d stable=%0d want 1 4 1", got, acc, stable);
    end
    vectors++;
    if (rsp_rdata !== mmem[0] || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_data: rdata=%h err=%b want %h 0", rsp_rdata, rsp_err, mmem[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit got, stable; int acc, rdy;
    slave_wait = 0;
    mmem[1] = 8'h11;
    mmem[2] = 8'h22;
    @(negedge PCLK); #1;
    drive_cmd(1, 1, 32'h01, 8'h11);
    @(negedge PCLK); #1;
    drive_cmd(1, 1, 32'h02, 8'h22);
    vectors++;
    if ({PSELx, PENABLE, cmd_ready} !== 3'b100 || PADDR !== 32'h01) begin
      miscompares++;
      $display("FAIL b2b_setup1: sel/en/rdy=%b addr=%h want 100 01", {PSELx, PENABLE, cmd_ready}, PADDR);
    end
    @(negedge PCLK); #1;
    vectors++;
    if ({PSELx, PENABLE, cmd_ready} !== 3'b111 || PADDR !== 32'h01) begin
      miscompares++;
      $display("FAIL b2b_access1: sel/en/rdy=%b addr=%h want 111 01", {PSELx, PENABLE, cmd_ready}, PADDR);
    end
    @(negedge PCLK); #1;
    drive_cmd(0, 0, AW'($urandom), DW'($urandom));
    vectors++;
    if ({PSELx, PENABLE, rsp_valid, rsp_err} !== 4'b1010 || PADDR !== 32'h02 || PWDATA !== 8'h22) begin
      miscompares++;
      $display("FAIL b2b_setup2: sel/en/rv/err=%b addr=%h wdata=%h want 1010 02 22",
               {PSELx, PENABLE, rsp_valid, rsp_err}, PADDR, PWDATA);
    end
    run_to_rsp(1'b1, 32'h02, 8'h22, got, acc, rdy, stable);
    vectors++;
    if (!got || acc != 1 || !stable || rsp_err !== 1'b0 || PSELx !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_rsp2: got=%0d access_cycles=%0d stable=%0d err=%b sel=%b want 1 1 1 0 0",
               got, acc, stable, rsp_err, PSELx);
    end
  endtask

  task automatic test_timeout();
    bit got, stable; int acc, rdy;
    logic [DW-1:0] wd;
    wd = DW'($urandom);
    slave_wait = 1000;
    @(negedge PCLK); #1;
    drive_cmd(1, 0, 32'h23, wd);
    @(negedge PCLK); #1;
    drive_cmd(0, 0, '0, '0);
    run_to_rsp(1'b0, 32'h23, wd, got, acc, rdy, stable);
    vectors++;
    if (!got || acc != int'(TO) || rdy != 0 || !stable) begin
      miscompares++;
      $display("FAIL to_access: got=%0d access_cycles=%0d ready_cycles=%0d stable=%0d want 1 %0d 0 1",
               got, acc, rdy, stable, TO);
    end
    vectors++;
    if ({PSELx, PENABLE, rsp_err, cmd_ready} !== 4'b0011 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL to_rsp: sel/en/err/rdy=%b rdata=%h want 0011 00",
               {PSELx, PENABLE, rsp_err, cmd_ready}, rsp_rdata);
    end
    @(negedge PCLK); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
      miscompares++; $display("FAIL to_hold: rsp_valid=%b err=%b want 0 1", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_ready_on_last();
    bit got, stable; int acc, rdy;
    logic [DW-1:0] wd;
    wd = DW'($urandom);
    slave_wait = int'(TO) - 1;
    @(negedge PCLK); #1;
    drive_cmd(1, 0, 32'h05, wd);
    @(negedge PCLK); #1;
    drive_cmd(0, 0, '0, '0);
    run_to_rsp(1'b0, 32'h05, wd, got, acc, rdy, stable);
    vectors++;
    if (!got || acc != int'(TO) || rdy != 1) begin
      miscompares++;
      $display("FAIL last_access: got=%0d access_cycles=%0d ready_cycles=%0d want 1 %0d 1", got, acc, rdy, TO);
    end
    vectors++;
    if (rsp_err !== 1'b0 || rsp_rdata !== mmem[5]) begin
      miscompares++;
      $display("FAIL last_rsp: err=%b rdata=%h want 0 %h", rsp_err, rsp_rdata, mmem[5]);
    end
  endtask

  task automatic test_reset_mid_access();
    bit got, stable, seen; int acc, rdy;
    logic [DW-1:0] wd;
    slave_wait = 1000;
    @(negedge PCLK); #1;
    drive_cmd(1, 0, 32'h07, DW'($urandom));
    @(negedge PCLK); #1;
    drive_cmd(0, 0, '0, '0);
    repeat (3) @(negedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    vectors++;
    if ({PSELx, PENABLE, rsp_valid} !== 3'b000 || PADDR !== '0) begin
      miscompares++;
      $display("FAIL rst_async: sel/en/rv=%b addr=%h want 000 0", {PSELx, PENABLE, rsp_valid}, PADDR);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK); #1;
      if (rsp_valid === 1'b1) seen = 1;
      if (i == 1) PRESETn = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL rst_norsp: rsp_valid seen=%0d want 0", seen);
    end
    wd = DW'($urandom);
    mmem[8] = wd;
    slave_wait = 1;
    drive_cmd(1, 1, 32'h08, wd);
    @(negedge PCLK); #1;
    drive_cmd(0, 0, '0, '0);
    run_to_rsp(1'b1, 32'h08, wd, got, acc, rdy, stable);
    vectors++;
    if (!got || acc != 2 || !stable || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after: got=%0d access_cycles=%0d stable=%0d err=%b want 1 2 1 0",
               got, acc, stable, rsp_err);
    end
  endtask

  task automatic test_random(input int n);
    bit got, stable; int acc, rdy, waits, exp_acc;
    logic w, exp_err;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, exp_rd;
    logic [3:0] idx;
    for (int t = 0; t < n; t++) begin
      w = 1'($urandom);
      a = AW'($urandom);
      wd = DW'($urandom);
      idx = a[3:0];
      case ($urandom_range(0, 7))
        5: waits = int'(TO) - 1;
        6: waits = int'(TO);
        7: waits = int'(TO) + 5;
        default: waits = int'($urandom_range(0, 4));
      endcase
      exp_err = (waits >= int'(TO));
      exp_acc = exp_err ? int'(TO) : waits + 1;
      exp_rd = '0;
      if (!exp_err) begin
        if (w) mmem[idx] = wd;
        else exp_rd = mmem[idx];
      end
      slave_wait = waits;
      @(negedge PCLK); #1;
      vectors++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || PSELx !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_idle[%0d]: rdy=%b rv=%b sel=%b want 1 0 0", t, cmd_ready, rsp_valid, PSELx);
      end
      drive_cmd(1, w, a, wd);
      @(negedge PCLK); #1;
      drive_cmd(0, 1'($urandom), AW'($urandom), DW'($urandom));
      vectors++;
      if ({PSELx, PENABLE} !== 2'b10 || PADDR !== a || PWRITE !== w || PWDATA !== wd) begin
        miscompares++;
        $display("FAIL rnd_setup[%0d]: sel/en=%b addr=%h wr=%b wdata=%h want 10 %h %b %h",
                 t, {PSELx, PENABLE}, PADDR, PWRITE, PWDATA, a, w, wd);
      end
      run_to_rsp(w, a, wd, got, acc, rdy, stable);
      vectors++;
      if (!got || acc != exp_acc || rdy != (exp_err ? 0 : 1) || !stable) begin
        miscompares++;
        $display("FAIL rnd_access[%0d]: got=%0d cycles=%0d ready=%0d stable=%0d want 1 %0d %0d 1",
                 t, got, acc, rdy, stable, exp_acc, exp_err ? 0 : 1);
      end
      vectors++;
      if (rsp_err !== exp_err || rsp_rdata !== exp_rd || PSELx !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_rsp[%0d]: err=%b rdata=%h sel=%b want %b %h 0",
                 t, rsp_err, rsp_rdata, PSELx, exp_err, exp_rd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      smem[i] = DW'($urandom);
      mmem[i] = smem[i];
    end
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_back_to_back();
    test_timeout();
    test_ready_on_last();
    test_reset_mid_access();
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
